mems_frame_writer: RTL and testbench



---
 rtl/mems_frame_pkg.sv | 17 +
 rtl/mems_frame_csum.sv | 31 +++
 rtl/mems_frame_writer.sv | 134 +++++++++++++
 tb/tb_mems_frame_writer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mems_frame_pkg.sv
// Shared definitions for the MEMS frame writer: default frame geometry,
// sync word and the writer state encoding.
package mems_frame_pkg;

  localparam int          DEF_FRAME_LEN = 520;
  localparam logic [15:0] DEF_SYNC_WORD = 16'hA5A5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_CNT,
    ST_DATA,
    ST_CSUM,
    ST_DRAIN
  } frame_state_e;

endpackage

// File: rtl/mems_frame_csum.sv
// Running 16-bit checksum of the samples written into a frame.
// Sum wraps modulo 2^16; the carry is discarded.
module mems_frame_csum (
  input  logic        clk_150MHz_i,
  input  logic        clear_i,
  input  logic        add_i,
  input  logic [15:0] data_i,
  output logic [15:0] sum_o
);

  logic [15:0] sum_q;
  logic [15:0] sum_d;

  // Next value: clear at the start of every frame, otherwise accumulate accepted samples.
  always_comb begin
    sum_d = sum_q;
    if (clear_i) begin
      sum_d = '0;
    end else if (add_i) begin
      sum_d = sum_q + data_i;
    end
  end

  // Accumulator register; the frame start clear makes a reset unnecessary.
  always_ff @(posedge clk_150MHz_i) begin
    sum_q <= sum_d;
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/mems_frame_writer.sv
// Frames ADC samples into the dual-clock line FIFO:
//   SYNC_WORD, frame counter, FRAME_LEN-3 samples, checksum word.
// After the last word it waits for the FIFO to drain and pulses frame_done_o.
// Build option: define MEMS_FRAME_CSUM_EN to emit the sample checksum as the
// last word; otherwise the last word is 16'h0000 and no accumulator is built.
module mems_frame_writer
  import mems_frame_pkg::*;
#(
  parameter int          FRAME_LEN = DEF_FRAME_LEN,
  parameter logic [15:0] SYNC_WORD = DEF_SYNC_WORD
) (
  input  logic        clk_150MHz_i,
  input  logic        reset,
  input  logic        frame_start_i,
  input  logic        sample_valid_i,
  input  logic [15:0] sample_data_i,
  input  logic        wrfull_i,
  input  logic [9:0]  wrusedw_i,
  output logic        wreq_o,
  output logic [15:0] wdata_o,
  output logic        frame_done_o,
  output logic        busy_o,
  output logic        overflow_o
);

  localparam int               CNT_W    = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 4);

  frame_state_e     state_q;
  logic [15:0]      frm_cnt_q;
  logic [CNT_W-1:0] smp_cnt_q;
  logic             wreq_q;
  logic [15:0]      wdata_q;
  logic             done_q;
  logic             busy_q;
  logic             ovf_q;

  logic             accept;
  logic [15:0]      csum_w;

  // A sample is taken only in DATA, when offered and the FIFO has room.
  assign accept = (state_q == ST_DATA) && sample_valid_i && !wrfull_i;

`ifdef MEMS_FRAME_CSUM_EN
  mems_frame_csum u_csum (
    .clk_150MHz_i (clk_150MHz_i),
    .clear_i      (state_q == ST_SYNC),
    .add_i        (accept),
    .data_i       (sample_data_i),
    .sum_o        (csum_w)
  );
`else
  assign csum_w = '0;
`endif

  // Frame sequencer with registered FIFO write port and status outputs.
  always_ff @(posedge clk_150MHz_i) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      frm_cnt_q <= '0;
      smp_cnt_q <= '0;
      wreq_q    <= 1'b0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wreq_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (frame_start_i) begin
            state_q <= ST_SYNC;
            busy_q  <= 1'b1;
          end
        end
        ST_SYNC: begin
          if (!wrfull_i) begin
            wreq_q  <= 1'b1;
            wdata_q <= SYNC_WORD;
            state_q <= ST_CNT;
          end
        end
        ST_CNT: begin
          if (!wrfull_i) begin
            wreq_q    <= 1'b1;
            wdata_q   <= frm_cnt_q;
            smp_cnt_q <= '0;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (accept) begin
            wreq_q    <= 1'b1;
            wdata_q   <= sample_data_i;
            smp_cnt_q <= smp_cnt_q + CNT_W'(1);
            if (smp_cnt_q == LAST_IDX) begin
              state_q <= ST_CSUM;
            end
          end else if (sample_valid_i) begin
            // FIFO full: the sample is lost and the loss is remembered until reset.
            ovf_q <= 1'b1;
          end
        end
        ST_CSUM: begin
          if (!wrfull_i) begin
            wreq_q    <= 1'b1;
            wdata_q   <= csum_w;
            frm_cnt_q <= frm_cnt_q + 16'd1;
            state_q   <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if ((wrusedw_i == '0) && !wrfull_i) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wreq_o       = wreq_q;
  assign wdata_o      = wdata_q;
  assign frame_done_o = done_q;
  assign busy_o       = busy_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_mems_frame_writer.sv
// Directed bench for mems_frame_writer: full frames, FIFO-full stalls,
// overflow, back-to-back frames and reset mid-frame.
module tb_mems_frame_writer;

  logic        clk_150MHz_i = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start_i = 1'b0;
  logic        sample_valid_i = 1'b0;
  logic [15:0] sample_data_i = '0;
  logic        wrfull_i = 1'b0;
  logic [9:0]  wrusedw_i = 10'd7;
  logic        wreq_o;
  logic [15:0] wdata_o;
  logic        frame_done_o;
  logic        busy_o;
  logic        overflow_o;

  int          n_cmp = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  int          viol = 0;
  logic        full_prev = 1'b0;
  logic [15:0] wq[$];
  logic [15:0] exp_q[$];
  logic [15:0] exp_sum;

  mems_frame_writer dut (
    .clk_150MHz_i   (clk_150MHz_i),
    .reset          (reset),
    .frame_start_i  (frame_start_i),
    .sample_valid_i (sample_valid_i),
    .sample_data_i  (sample_data_i),
    .wrfull_i       (wrfull_i),
    .wrusedw_i      (wrusedw_i),
    .wreq_o         (wreq_o),
    .wdata_o        (wdata_o),
    .frame_done_o   (frame_done_o),
    .busy_o         (busy_o),
    .overflow_o     (overflow_o)
  );

  always #3 clk_150MHz_i = ~clk_150MHz_i;

  // wrfull_i as seen in the cycle that decides the next wreq_o
  always @(posedge clk_150MHz_i) full_prev <= wrfull_i;

  // Collect every written word and count frame_done_o pulses
  always @(negedge clk_150MHz_i) begin
    if (wreq_o) begin
      wq.push_back(wdata_o);
      if (full_prev) viol++;
    end
    if (frame_done_o) done_cnt++;
  end

  task automatic step();
    @(posedge clk_150MHz_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame();
    frame_start_i = 1'b1;
    step();
    frame_start_i = 1'b0;
    step();
    step();
  endtask

  // Offer one sample per cycle until n are accepted; model drops while full
  task automatic feed(input int n, input int base, input int full_from,
                      input int full_len, input int inj);
    int acc = 0;
    int c = 0;
    while (acc < n && c < 3000) begin
      wrfull_i       = (c >= full_from) && (c < full_from + full_len);
      frame_start_i  = (c == inj);
      sample_valid_i = 1'b1;
      sample_data_i  = 16'(base + c);
      if (!wrfull_i) begin
        exp_q.push_back(sample_data_i);
        exp_sum = exp_sum + sample_data_i;
        acc++;
      end
      step();
      c++;
    end
    sample_valid_i = 1'b0;
    wrfull_i       = 1'b0;
    frame_start_i  = 1'b0;
    check("feed_accepted", acc, n);
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_150MHz_i);
      if (done_cnt != 0) break;
    end
    check({tag, "_done_seen"}, done_cnt, 1);
    step(); step(); step();
    @(negedge clk_150MHz_i);
    check({tag, "_done_single"}, done_cnt, 1);
    check({tag, "_idle_busy"}, busy_o, 1'b0);
  endtask

  task automatic check_frame(input string tag, input logic [15:0] cnt, input logic [15:0] csum);
    int bad = 0;
    check({tag, "_len"}, wq.size(), 520);
    if (wq.size() == 520) begin
      check({tag, "_sync"}, wq[0], 16'hA5A5);
      check({tag, "_counter"}, wq[1], cnt);
      for (int i = 0; i < 517; i++) if (wq[i+2] !== exp_q[i]) bad++;
      check({tag, "_samples_bad"}, bad, 0);
`ifdef MEMS_FRAME_CSUM_EN
      check({tag, "_csum"}, wq[519], csum);
`else
      check({tag, "_last_zero"}, wq[519], 16'h0000);
`endif
    end
  endtask

  initial begin
    // Reset values
    step(); step();
    @(negedge clk_150MHz_i);
    check("rst_wreq", wreq_o, 1'b0);
    check("rst_wdata", wdata_o, 16'h0000);
    check("rst_done", frame_done_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_ovf", overflow_o, 1'b0);
    step();
    reset = 1'b0;
    step();

    // Frame 1: samples 1..517, no stalls, drain held off by wrusedw_i
    wq.delete(); exp_q.delete(); exp_sum = '0; done_cnt = 0;
    frame_start_i = 1'b1;
    step();
    frame_start_i = 1'b0;
    @(negedge clk_150MHz_i);
    check("f1_sync_not_early", wreq_o, 1'b0);
    check("f1_busy", busy_o, 1'b1);
    step();
    @(negedge clk_150MHz_i);
    check("f1_sync_wreq", wreq_o, 1'b1);
    check("f1_sync_data", wdata_o, 16'hA5A5);
    step();
    feed(517, 1, -1, 0, -1);
    step(); step(); step(); step(); step();
    @(negedge clk_150MHz_i);
    check("f1_drain_wait_done", done_cnt, 0);
    check("f1_drain_busy", busy_o, 1'b1);
    wrusedw_i = 10'd0;
    wait_done("f1");
    // 1+2+..+517 = 133903; 133903 - 2*65536 = 2831 = 16'h0B0F
    check_frame("f1", 16'h0000, 16'h0B0F);
    check("f1_no_ovf", overflow_o, 1'b0);

    // Frame 2: 5 full cycles during DATA, stray frame_start_i mid-frame
    wq.delete(); exp_q.delete(); exp_sum = '0; done_cnt = 0;
    start_frame();
    feed(517, 1000, 50, 5, 200);
    @(negedge clk_150MHz_i);
    check("f2_ovf_set", overflow_o, 1'b1);
    wait_done("f2");
    check_frame("f2", 16'h0001, exp_sum);
    step(); step();
    @(negedge clk_150MHz_i);
    check("f2_start_not_queued", busy_o, 1'b0);
    check("f2_ovf_sticky", overflow_o, 1'b1);

    // Frame 3: FIFO full for 3 cycles in SYNC, then reset at sample 100
    wq.delete(); exp_q.delete(); exp_sum = '0; done_cnt = 0;
    frame_start_i = 1'b1;
    step();
    frame_start_i = 1'b0;
    wrfull_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_150MHz_i);
      check("f3_sync_stall", wreq_o, 1'b0);
      step();
    end
    wrfull_i = 1'b0;
    @(negedge clk_150MHz_i);
    check("f3_sync_stall_last", wreq_o, 1'b0);
    step();
    @(negedge clk_150MHz_i);
    check("f3_sync_wreq", wreq_o, 1'b1);
    check("f3_sync_data", wdata_o, 16'hA5A5);
    step();
    feed(100, 16'h2000, -1, 0, -1);
    reset = 1'b1;
    step();
    @(negedge clk_150MHz_i);
    check("f3_rst_wreq", wreq_o, 1'b0);
    check("f3_rst_wdata", wdata_o, 16'h0000);
    check("f3_rst_done", frame_done_o, 1'b0);
    check("f3_rst_busy", busy_o, 1'b0);
    check("f3_rst_ovf", overflow_o, 1'b0);
    check("f3_partial_len", wq.size(), 102);
    if (wq.size() >= 2) check("f3_counter", wq[1], 16'h0002);
    step();
    reset = 1'b0;
    step();

    // Frame 4: counter restarts at 0, sample values wrap through 16'hFFFF
    wq.delete(); exp_q.delete(); exp_sum = '0; done_cnt = 0;
    start_frame();
    feed(517, 16'hFF00, -1, 0, -1);
    wait_done("f4");
    check_frame("f4", 16'h0000, exp_sum);

    check("wreq_while_full", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
